// File: rtl/color_scheduler.sv
// Time-shares one S2/S3 filter bus and one edge-count engine between the object and
// station TCS3200 colour sensors, classifying each RGB frame into a debounced colour code.
module color_scheduler #(
    parameter int unsigned WINDOW  = 50000,
    parameter int unsigned SETTLE  = 500,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MIN_CNT = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_object,
    input  logic       en_station,
    input  logic       freq_object,
    input  logic       freq_station,
    output logic       s2,
    output logic       s3,
    output logic       sensor_sel,
    output logic       busy,
    output logic [1:0] object_color,
    output logic [1:0] station_color,
    output logic       object_valid,
    output logic       station_valid
);

    localparam int unsigned TMR_W = $clog2(WINDOW > SETTLE ? WINDOW : SETTLE) + 1;

    typedef enum logic [1:0] {StIdle, StSettle, StCount, StClassify} state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]         filt_q, filt_d;
    logic               sel_q, sel_d;
    logic               last_q, last_d;
    logic               s2_q, s2_d, s3_q, s3_d;
    logic [CNT_W-1:0]   cnt_r_q, cnt_r_d, cnt_g_q, cnt_g_d, cnt_b_q, cnt_b_d;
    logic [1:0]         obj_color_q, obj_color_d, sta_color_q, sta_color_d;
    logic [1:0]         obj_prev_q, obj_prev_d, sta_prev_q, sta_prev_d;
    logic               obj_valid_q, obj_valid_d, sta_valid_q, sta_valid_d;

    logic [1:0]         obj_sync_q, sta_sync_q;
    logic               obj_last_q, sta_last_q;
    logic               obj_rise, sta_rise, sel_rise, sel_en, new_frame;
    logic [1:0]         cls;

    always_ff @(posedge clk) begin
        if (rst) begin
            obj_sync_q <= '0;
            sta_sync_q <= '0;
            obj_last_q <= 1'b0;
            sta_last_q <= 1'b0;
        end else begin
            obj_sync_q <= {obj_sync_q[0], freq_object};
            sta_sync_q <= {sta_sync_q[0], freq_station};
            obj_last_q <= obj_sync_q[1];
            sta_last_q <= sta_sync_q[1];
        end
    end

    assign obj_rise = obj_sync_q[1] & ~obj_last_q;
    assign sta_rise = sta_sync_q[1] & ~sta_last_q;
    assign sel_rise = sel_q ? sta_rise : obj_rise;
    assign sel_en   = sel_q ? en_station : en_object;

    function automatic logic [1:0] classify(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] g,
                                            input logic [CNT_W-1:0] b);
        logic [1:0] c;
        c = 2'd0;
        if (r > g && r > b && r >= CNT_W'(MIN_CNT)) begin
            c = 2'd1;
        end else if (g > r && g > b && g >= CNT_W'(MIN_CNT)) begin
            c = 2'd2;
        end else if (b > r && b > g && b >= CNT_W'(MIN_CNT)) begin
            c = 2'd3;
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    // Filter index 0/1/2 = red/green/blue mapped onto {s2, s3}.
    function automatic logic [1:0] filter_bits(input logic [1:0] idx);
        logic [1:0] bits;
        case (idx)
            2'd1:    bits = 2'b11;
            2'd2:    bits = 2'b01;
            default: bits = 2'b00;
        endcase
        return bits;
    endfunction

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        filt_d      = filt_q;
        sel_d       = sel_q;
        last_d      = last_q;
        s2_d        = s2_q;
        s3_d        = s3_q;
        cnt_r_d     = cnt_r_q;
        cnt_g_d     = cnt_g_q;
        cnt_b_d     = cnt_b_q;
        obj_color_d = obj_color_q;
        sta_color_d = sta_color_q;
        obj_prev_d  = obj_prev_q;
        sta_prev_d  = sta_prev_q;
        obj_valid_d = 1'b0;
        sta_valid_d = 1'b0;
        new_frame   = 1'b0;
        cls         = classify(cnt_r_q, cnt_g_q, cnt_b_q);

        unique case (state_q)
            StIdle: begin
                new_frame = en_object | en_station;
            end
            StSettle: begin
                if (!sel_en) begin
                    new_frame = 1'b1;
                end else if (timer_q == TMR_W'(SETTLE - 1)) begin
                    state_d = StCount;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StCount: begin
                if (!sel_en) begin
                    new_frame = 1'b1;
                end else begin
                    if (sel_rise) begin
                        case (filt_q)
                            2'd0:    cnt_r_d = sat_inc(cnt_r_q);
                            2'd1:    cnt_g_d = sat_inc(cnt_g_q);
                            default: cnt_b_d = sat_inc(cnt_b_q);
                        endcase
                    end
                    if (timer_q == TMR_W'(WINDOW - 1)) begin
                        timer_d = '0;
                        if (filt_q == 2'd2) begin
                            state_d = StClassify;
                        end else begin
                            filt_d       = filt_q + 2'd1;
                            {s2_d, s3_d} = filter_bits(filt_q + 2'd1);
                            state_d      = StSettle;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            StClassify: begin
                new_frame = 1'b1;
                // An enable dropping in this cycle aborts: no update, no pulse.
                if (sel_en) begin
                    if (sel_q) begin
                        sta_valid_d = 1'b1;
                        if (cls == sta_prev_q) sta_color_d = cls;
                        else                   sta_prev_d  = cls;
                    end else begin
                        obj_valid_d = 1'b1;
                        if (cls == obj_prev_q) obj_color_d = cls;
                        else                   obj_prev_d  = cls;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (new_frame) begin
            timer_d = '0;
            filt_d  = 2'd0;
            cnt_r_d = '0;
            cnt_g_d = '0;
            cnt_b_d = '0;
            if (en_object | en_station) begin
                state_d      = StSettle;
                sel_d        = (en_object & en_station) ? ~last_q : en_station;
                last_d       = sel_d;
                {s2_d, s3_d} = filter_bits(2'd0);
            end else begin
                state_d = StIdle;
            end
        end

        if (!en_object) begin
            obj_color_d = 2'd0;
            obj_prev_d  = 2'd0;
        end
        if (!en_station) begin
            sta_color_d = 2'd0;
            sta_prev_d  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            filt_q      <= 2'd0;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            cnt_r_q     <= '0;
            cnt_g_q     <= '0;
            cnt_b_q     <= '0;
            obj_color_q <= 2'd0;
            sta_color_q <= 2'd0;
            obj_prev_q  <= 2'd0;
            sta_prev_q  <= 2'd0;
            obj_valid_q <= 1'b0;
            sta_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            filt_q      <= filt_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            cnt_r_q     <= cnt_r_d;
            cnt_g_q     <= cnt_g_d;
            cnt_b_q     <= cnt_b_d;
            obj_color_q <= obj_color_d;
            sta_color_q <= sta_color_d;
            obj_prev_q  <= obj_prev_d;
            sta_prev_q  <= sta_prev_d;
            obj_valid_q <= obj_valid_d;
            sta_valid_q <= sta_valid_d;
        end
    end

    assign s2            = s2_q;
    assign s3            = s3_q;
    assign sensor_sel    = sel_q;
    assign busy          = (state_q != StIdle);
    assign object_color  = obj_color_q;
    assign station_color = sta_color_q;
    assign object_valid  = obj_valid_q;
    assign station_valid = sta_valid_q;

endmodule

// File: doc/color_scheduler.md
# color_scheduler

Shares the robot's single filter-select bus (S2/S3) and one frequency-measurement engine between the object color sensor and the station color sensor. It sequences red/green/blue measurement windows on whichever sensor Core has enabled (`en_object`, `en_station`) and classifies each frame. It presents debounced 2-bit color codes to Core: 0 none, 1 red, 2 green, 3 blue. Sits between the TCS3200-style sensors and Core, replacing free-running per-sensor color logic.

## Interface
- `WINDOW`, 50000: counting-window length in clk cycles per filter (1 ms at 50 MHz).
- `SETTLE`, 500: idle cycles after each filter change before counting.
- `CNT_W`, 16: edge-counter width.
- `MIN_CNT`, 20: minimum winning count for a valid color.
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `en_object` in 1: request measurement of the object sensor.
- `en_station` in 1: request measurement of the station sensor.
- `freq_object` in 1: object sensor frequency output (asynchronous).
- `freq_station` in 1: station sensor frequency output (asynchronous).
- `s2`, `s3` out 1 each: shared filter select. Red = 00, blue = 01, green = 11.
- `sensor_sel` out 1: sensor being measured (0 object, 1 station).
- `busy` out 1: high in any state except IDLE.
- `object_color` out 2: confirmed object color.
- `station_color` out 2: confirmed station color.
- `object_valid`, `station_valid` out 1 each: one-cycle pulse at the end of each frame for that sensor.

## Operation
- Both `freq_*` inputs pass through 2-flop synchronizers and a rising-edge detector. Only the selected sensor's edges are counted.
- FSM states:
  - IDLE
  - SETTLE: counts SETTLE cycles.
  - COUNT: counts WINDOW cycles.
  - CLASSIFY: 1 cycle.
- Filter order within a frame is red, green, blue. The filter index advances on COUNT→SETTLE. After the blue COUNT the FSM goes to CLASSIFY.
- Arbitration happens at frame start, i.e. on IDLE exit or on CLASSIFY exit:
  - Both enables high: choose the sensor opposite to `last_sel` (round-robin per frame).
  - One enable high: choose that sensor.
  - Neither high: go to IDLE.
  - `last_sel` resets to station, so the object sensor is served first.
- Edge counters r/g/b (CNT_W bits) clear at frame start. They saturate at all-ones; no wrap.
- Classification: the winner is the strictly largest count, and it must be >= MIN_CNT. Any tie for the maximum, or a maximum below MIN_CNT, yields 0.
- Confirmation, kept per sensor in `prev_*`:
  - If the classification equals `prev`, the output register takes that value.
  - Otherwise the output register holds and `prev` is set to the classification.
  - `*_valid` pulses either way.
- Disable mid-frame: the selected sensor's enable going low aborts the frame.
  - The FSM goes to IDLE on the next edge (or re-arbitrates if the other enable is high).
  - Counts are discarded and no valid pulse is issued.
- A disabled sensor gets its color output and `prev` cleared to 0 on the next edge, whether or not it is selected.
- Reset values: FSM IDLE; `s2`=0, `s3`=0, `sensor_sel`=0, `busy`=0; both colors 0; both valids 0; both `prev` 0; counters 0; `last_sel`=1.

## Timing
- Edge-to-count latency is 3 cycles (sync plus edge detect). Edges detected during the COUNT cycles of a window are counted; edges in SETTLE are ignored.
- `s2`/`s3` are registered and change on the edge entering the SETTLE of the new filter.
- Frame length is 3·(SETTLE+WINDOW)+1 cycles, from the first SETTLE cycle through the CLASSIFY cycle.
- Color outputs and the valid pulse are registered on the edge leaving CLASSIFY. They are visible the cycle after CLASSIFY.
- A fresh stable color is confirmed on its second frame, so worst-case Core latency is about 2 frames (~6 ms default) with one sensor active. With both sensors active it is about 4 frames.
- Enable sampling: an enable rising while the FSM is IDLE starts SETTLE on the next edge.
- Simultaneous enable drop and CLASSIFY: the abort wins. No update and no pulse.
- `rst` overrides everything on the same edge, including mid-COUNT.

## Test plan
Bench uses WINDOW=100, SETTLE=4, MIN_CNT=5. The sensor model's period depends on `s2`/`s3`.

- Object red: only `en_object` high; red period 4, green/blue period 20 (about 25/5/5 edges).
  - Frame 1: `object_valid` at cycle ~314, `object_color` stays 0.
  - Frame 2: `object_color`=1 after ~627 cycles.
  - `station_color` stays 0 throughout.
- Round-robin: both enables high, station blue, object green.
  - `sensor_sel` alternates 0,1,0,1 every 313 cycles.
  - After 4 frames: `object_color`=2, `station_color`=3.
- Low light: all periods 40 (2–3 edges per window) → both frames classify 0 and `object_color` stays 0.
- Tie: red and green both period 5, blue period 20 → classification 0.
- Abort: drop `en_object` at the 50th cycle of the green COUNT.
  - Next cycle: `busy`=0, `object_color`=0.
  - No `object_valid` pulse.
- Reset mid-frame: assert `rst` for 1 cycle mid-COUNT.
  - Next cycle all outputs are at their reset values.
  - After release, the first served sensor is the object sensor.
